pe_array_ctrl: RTL
==================

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 SHALL have parameter NUM_PE, default 4, number of PEs sequenced; power of 2, range 1..16.
REQ-002 SHALL have parameter TIMEOUT, default 1023, maximum wait cycles per PE phase.
REQ-003 SHALL have port Clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 SHALL have port Start  input  1  host job request, sampled in IDLE only.
REQ-006 SHALL have port Ack  input  1  host acknowledge of done.
REQ-007 SHALL have port threshold_in, bg_r_in, bg_g_in, bg_b_in  input  8 each  job configuration.
REQ-008 SHALL have port pe_sum_r, pe_sum_g, pe_sum_b  input  8*NUM_PE each  per-PE sum results; PE k in bits [8k+7:8k].
REQ-009 SHALL have port pe_sum_done  input  NUM_PE  per-PE sum-done flags (PE Qsd).
REQ-010 SHALL have port pe_bg_done  input  NUM_PE  per-PE removal-done flags (PE Qbgd).
REQ-011 SHALL have port pe_start_sum, pe_start_bg, pe_ack  output  1 each  broadcast PE controls.
REQ-012 SHALL have port red_exp, green_exp, blue_exp  output  8 each  averaged expected background colour.
REQ-013 SHALL have port threshold, desired_bg_r, desired_bg_g, desired_bg_b  output  8 each  latched configuration.
REQ-014 SHALL have port busy, done, error  output  1 each  host status.
REQ-015 SHALL have port state  output  3  current state encoding.

Function
REQ-016 SHALL implement states IDLE=0, SUM_START=1, SUM_WAIT=2, AVG=3, BG_START=4, BG_WAIT=5, DONE=6; state output equals encoding.
REQ-017 IDLE: Start=1 -> SUM_START; SHALL latch threshold_in, bg_*_in into config outputs and clear error on that edge.
REQ-018 Start SHALL be ignored in every state except IDLE; config outputs SHALL hold during a job.
REQ-019 SUM_START: pe_start_sum=1 for exactly this one cycle; -> SUM_WAIT unconditionally.
REQ-020 SUM_WAIT: all pe_sum_done bits 1 -> AVG; wait counter increments each cycle otherwise.
REQ-021 AVG: SHALL last exactly NUM_PE cycles, adding PE index i (0..NUM_PE-1, one per cycle) to three (8+log2 NUM_PE)-bit accumulators; no overflow possible.
REQ-022 On AVG exit, red/green/blue_exp SHALL load accumulator >> log2(NUM_PE) (truncation); -> BG_START.
REQ-023 BG_START: pe_start_bg=1 for exactly one cycle, exp outputs already valid; -> BG_WAIT.
REQ-024 BG_WAIT: all pe_bg_done bits 1 -> DONE; wait counter increments otherwise.
REQ-025 Wait counter SHALL clear on entry to SUM_WAIT and BG_WAIT; reaching TIMEOUT -> DONE with error=1, exp outputs unchanged.
REQ-026 pe_ack SHALL be 1 in SUM_WAIT, AVG, BG_START, BG_WAIT, DONE; 0 in IDLE, SUM_START.
REQ-027 DONE: done=1; Ack=1 -> IDLE; done held indefinitely while Ack=0.
REQ-028 Ack=1 outside DONE SHALL have no effect.
REQ-029 busy SHALL be 1 in all states except IDLE and DONE.
REQ-030 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.
REQ-031 Done flags already 1 on SUM_WAIT entry SHALL be accepted (transition after one cycle in SUM_WAIT).

Reset
REQ-032 Reset=0 SHALL immediately force IDLE, clear counters, accumulators and index, regardless of state, including mid-AVG.
REQ-033 Reset values: all outputs 0 (pe_start_*, pe_ack, exp, config, busy, done, error, state).
REQ-034 After Reset release, first Start SHALL be accepted on the first rising edge with Reset=1.

Verification (NUM_PE=4)
REQ-035 Nominal: Start, threshold_in=30, bg_*_in=10; PE red sums 61,65,57,61, green 133x4, blue 198x4; done bits set 5 cycles after pulse -> exp=61,133,198, one pe_start_sum and one pe_start_bg pulse, done=1, error=0.
REQ-036 Truncation: red sums 255,255,255,254 -> red_exp=254.
REQ-037 Timeout: pe_sum_done=4'b0111 held -> DONE after TIMEOUT+1 SUM_WAIT cycles, error=1, no pe_start_bg pulse.
REQ-038 Handshake: Ack held 0 for 20 cycles in DONE -> done stays 1; Start pulses during job and in DONE ignored; Ack=1 -> IDLE next edge.
REQ-039 Reset mid-AVG (cycle 2) -> all outputs 0 asynchronously; subsequent nominal job yields REQ-035 results.
REQ-040 Pre-set done: all done bits already 1 -> SUM_WAIT and BG_WAIT each occupy one cycle; total Start-to-DONE latency 1+1+1+4+1+1 = 9 cycles.

Source files
------------

// File: rtl/pe_array_ctrl_if.sv
// pe_array_ctrl_if -- host and PE-array signal bundle for pe_array_ctrl.
//   Host side : Start, Ack, threshold_in, bg_r/g/b_in (in)
//               threshold, desired_bg_r/g/b, busy, done, error, state (out)
//   PE side   : pe_sum_r/g/b (8 bits per PE, PE k at [8k+7:8k]),
//               pe_sum_done, pe_bg_done (in)
//               pe_start_sum, pe_start_bg, pe_ack, red/green/blue_exp (out)
//   The master modport is the environment (host + PEs); slave is the controller.
interface pe_array_ctrl_if #(
  parameter int NUM_PE = 4
);
  logic                  Start;
  logic                  Ack;
  logic [7:0]            threshold_in;
  logic [7:0]            bg_r_in;
  logic [7:0]            bg_g_in;
  logic [7:0]            bg_b_in;
  logic [8*NUM_PE-1:0]   pe_sum_r;
  logic [8*NUM_PE-1:0]   pe_sum_g;
  logic [8*NUM_PE-1:0]   pe_sum_b;
  logic [NUM_PE-1:0]     pe_sum_done;
  logic [NUM_PE-1:0]     pe_bg_done;
  logic                  pe_start_sum;
  logic                  pe_start_bg;
  logic                  pe_ack;
  logic [7:0]            red_exp;
  logic [7:0]            green_exp;
  logic [7:0]            blue_exp;
  logic [7:0]            threshold;
  logic [7:0]            desired_bg_r;
  logic [7:0]            desired_bg_g;
  logic [7:0]            desired_bg_b;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [2:0]            state;

  modport master (
    output Start, Ack, threshold_in, bg_r_in, bg_g_in, bg_b_in,
           pe_sum_r, pe_sum_g, pe_sum_b, pe_sum_done, pe_bg_done,
    input  pe_start_sum, pe_start_bg, pe_ack, red_exp, green_exp, blue_exp,
           threshold, desired_bg_r, desired_bg_g, desired_bg_b,
           busy, done, error, state
  );

  modport slave (
    input  Start, Ack, threshold_in, bg_r_in, bg_g_in, bg_b_in,
           pe_sum_r, pe_sum_g, pe_sum_b, pe_sum_done, pe_bg_done,
    output pe_start_sum, pe_start_bg, pe_ack, red_exp, green_exp, blue_exp,
           threshold, desired_bg_r, desired_bg_g, desired_bg_b,
           busy, done, error, state
  );
endinterface

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl -- sequences a PE array through a sum phase, averages the
// per-PE colour sums into an expected background colour, then runs a
// background-removal phase and reports completion to the host.
//   Clk   : system clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : pe_array_ctrl_if slave modport (host + PE signals)
// Every output is a register; no input reaches an output combinationally.
module pe_array_ctrl #(
  parameter int NUM_PE  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic           Clk,
  input  logic           Reset,
  pe_array_ctrl_if.slave bus
);
  localparam int LOG2 = (NUM_PE > 1) ? $clog2(NUM_PE) : 0;
  localparam int IDXW = (LOG2 > 0) ? LOG2 : 1;
  localparam int ACCW = 8 + LOG2;
  localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(TIMEOUT);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_PE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SUM_START = 3'd1,
    SUM_WAIT  = 3'd2,
    AVG       = 3'd3,
    BG_START  = 3'd4,
    BG_WAIT   = 3'd5,
    DONE      = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] wait_cnt_q;
  logic [IDXW-1:0] idx_q;
  logic [ACCW-1:0] acc_r_q, acc_g_q, acc_b_q;
  logic [ACCW-1:0] acc_r_d, acc_g_d, acc_b_d;
  logic [7:0]      red_exp_q, green_exp_q, blue_exp_q;
  logic [7:0]      thr_q, bg_r_q, bg_g_q, bg_b_q;
  logic            start_sum_q, start_bg_q, ack_q, busy_q, done_q, error_q;
  logic            sum_all, bg_all, timeout_hit;

  logic [7:0] sum_r [NUM_PE];
  logic [7:0] sum_g [NUM_PE];
  logic [7:0] sum_b [NUM_PE];

  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_unpack
    assign sum_r[gi] = bus.pe_sum_r[8*gi +: 8];
    assign sum_g[gi] = bus.pe_sum_g[8*gi +: 8];
    assign sum_b[gi] = bus.pe_sum_b[8*gi +: 8];
  end

  assign sum_all     = &bus.pe_sum_done;
  assign bg_all      = &bus.pe_bg_done;
  assign timeout_hit = (wait_cnt_q == CNT_MAX);

  // One PE per AVG cycle; the accumulator is wide enough that it cannot wrap.
  assign acc_r_d = acc_r_q + ACCW'(sum_r[idx_q]);
  assign acc_g_d = acc_g_q + ACCW'(sum_g[idx_q]);
  assign acc_b_d = acc_b_q + ACCW'(sum_b[idx_q]);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.Start) state_d = SUM_START;
      SUM_START: state_d = SUM_WAIT;
      SUM_WAIT:  if (sum_all) state_d = AVG;
                 else if (timeout_hit) state_d = DONE;
      AVG:       if (idx_q == IDX_LAST) state_d = BG_START;
      BG_START:  state_d = BG_WAIT;
      BG_WAIT:   if (bg_all || timeout_hit) state_d = DONE;
      DONE:      if (bus.Ack) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      idx_q       <= '0;
      acc_r_q     <= '0;
      acc_g_q     <= '0;
      acc_b_q     <= '0;
      red_exp_q   <= '0;
      green_exp_q <= '0;
      blue_exp_q  <= '0;
      thr_q       <= '0;
      bg_r_q      <= '0;
      bg_g_q      <= '0;
      bg_b_q      <= '0;
      start_sum_q <= 1'b0;
      start_bg_q  <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Status flags are decoded from the next state so they line up with state_q.
      start_sum_q <= (state_d == SUM_START);
      start_bg_q  <= (state_d == BG_START);
      ack_q       <= (state_d != IDLE) && (state_d != SUM_START);
      busy_q      <= (state_d != IDLE) && (state_d != DONE);
      done_q      <= (state_d == DONE);
      // Counter only runs while staying in a wait state, so every entry starts at 0.
      if ((state_q == SUM_WAIT || state_q == BG_WAIT) && state_d == state_q)
        wait_cnt_q <= wait_cnt_q + 1'b1;
      else
        wait_cnt_q <= '0;

      unique case (state_q)
        IDLE: if (bus.Start) begin
          thr_q   <= bus.threshold_in;
          bg_r_q  <= bus.bg_r_in;
          bg_g_q  <= bus.bg_g_in;
          bg_b_q  <= bus.bg_b_in;
          error_q <= 1'b0;
        end
        SUM_WAIT: begin
          if (sum_all) begin
            acc_r_q <= '0;
            acc_g_q <= '0;
            acc_b_q <= '0;
            idx_q   <= '0;
          end else if (timeout_hit) begin
            error_q <= 1'b1;
          end
        end
        AVG: begin
          acc_r_q <= acc_r_d;
          acc_g_q <= acc_g_d;
          acc_b_q <= acc_b_d;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            // Divide by NUM_PE with truncation.
            red_exp_q   <= acc_r_d[ACCW-1:LOG2];
            green_exp_q <= acc_g_d[ACCW-1:LOG2];
            blue_exp_q  <= acc_b_d[ACCW-1:LOG2];
          end
        end
        BG_WAIT: if (!bg_all && timeout_hit) error_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.state        = state_q;
  assign bus.pe_start_sum = start_sum_q;
  assign bus.pe_start_bg  = start_bg_q;
  assign bus.pe_ack       = ack_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.red_exp      = red_exp_q;
  assign bus.green_exp    = green_exp_q;
  assign bus.blue_exp     = blue_exp_q;
  assign bus.threshold    = thr_q;
  assign bus.desired_bg_r = bg_r_q;
  assign bus.desired_bg_g = bg_g_q;
  assign bus.desired_bg_b = bg_b_q;
endmodule
